sharpen_window_gen: RTL
=======================

# sharpen_window_gen

Upstream feeder for the 3x3 sharpen MAC stage. Accepts a raster-order pixel stream one pixel per valid cycle and emits one full 3x3 neighbourhood (nine pixels, 72 bits at default width) per fully-covered input position, with a one-cycle valid strobe that drives the MAC's `inPixel`/`inPixelValid` directly. Internally it holds three rotating line buffers, per-row 3-tap shift registers, a column/row counter and a fill/run state machine.

## Interface
- `DATA_WIDTH`, 8: bits per pixel.
- `IMG_WIDTH`, 512: pixels per line. Minimum 3.
- `IMG_HEIGHT`, 512: lines per frame. Minimum 3.
- `clk` input 1: single clock; all logic rising-edge.
- `rst` input 1: reset, asynchronous and active-high.
- `inPixel` input DATA_WIDTH: incoming pixel, sampled when `inPixelValid`=1.
- `inPixelValid` input 1: input qualifier. No backpressure; every valid cycle is consumed.
- `outWindow` output 9*DATA_WIDTH: window; pixel (row r, col c) at `[DATA_WIDTH*(3*r+c) +: DATA_WIDTH]`. r=0 is the oldest line, c=0 is the leftmost column, index 4 is the centre.
- `outWindowValid` output 1: one-cycle strobe per emitted window.
- `frameDone` output 1: present only with `WINGEN_FRAME_DONE_EN`; one-cycle strobe.

## Operation
- Counters: `col` counts 0..IMG_WIDTH-1 and `row` counts 0..IMG_HEIGHT-1. Both advance only on accepted pixels. `col` wraps to 0 at IMG_WIDTH-1 and increments `row`.
- Line buffers: three RAMs of IMG_WIDTH entries. The write line index rotates 0→1→2→0 on each `col` wrap. The two non-write lines are read at address `col` in the same cycle as the write.
- Row taps: each of the three rows has a 3-deep shift register, loaded on every accepted pixel. The current line's tap takes `inPixel` directly. The other two taps take RAM read data, ordered oldest→row 0.
- State FILL (reset state): while `row`<2, no windows are emitted. Moves to RUN on the accept of pixel (1, IMG_WIDTH-1).
- State RUN: on accept of pixel (r,c) with c≥2, emit the window covering rows r-2..r and cols c-2..c. No window is emitted for c<2; there is no border padding.
- Frame end: on accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1):
  - the last window is emitted;
  - counters clear to 0;
  - state returns to FILL;
  - `frameDone` pulses (with the macro).
- Windows per frame: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Idle cycles (`inPixelValid`=0) anywhere: all state, counters and taps hold, and `outWindowValid`=0.
- Reset mid-frame: counters, state, taps and outputs clear immediately. RAM contents are not cleared; they are don't-care because FILL rewrites them before use.

## Timing
- Reset values: `outWindow`=0, `outWindowValid`=0, `frameDone`=0, state=FILL, `col`=`row`=0.
- Latency: a window is registered on the accepting edge and is visible the cycle after the input pixel is sampled.
- `outWindowValid` is high for exactly one cycle per window. `outWindow` holds its last value until the next window.
- Back-to-back valid input gives back-to-back windows within a line, plus a 2-accept gap at each line start.
- `frameDone` asserts in the same cycle as the final window's `outWindowValid`.
- RAM read is synchronous-write / same-address-read. Read data for address `col` must be the previous line's value, not the one being written. Lines rotate, so no read-during-write conflict exists.

## Configuration
- `WINGEN_FRAME_DONE_EN` defined: the `frameDone` port exists and pulses as described above.
- `WINGEN_FRAME_DONE_EN` undefined: the port and its register are absent; all other behaviour is identical.

## Test plan
- Reset check (IMG_WIDTH=4, IMG_HEIGHT=4): assert `rst` mid-cycle with no clock edge → all outputs read 0 immediately.
- Ramp frame (IMG_WIDTH=4, IMG_HEIGHT=4): feed pixels 0..15 continuously →
  - exactly 4 windows;
  - first window one cycle after pixel 10, equal to {0,1,2,4,5,6,8,9,10} (index 0..8);
  - last window {5,6,7,9,10,11,13,14,15};
  - `frameDone` coincides with the last window.
- Gapped input: same ramp with `inPixelValid` toggling 1,0 → identical window contents and count, with each window one cycle after its triggering pixel.
- Two frames back-to-back, second ramp 100..115 → second frame's first window is {100,101,102,104,105,106,108,109,110}, with no stale data from frame 1.
- Mid-frame reset after pixel 9, then a fresh ramp 0..15 → no window before pixel 10 of the new frame, and the output matches the clean ramp case.
- MAC integration with the default MAC: all-ones frame 8x8 → 36 windows of {9{8'h01}} delivered to the MAC with the valid strobes aligned.

Source files
------------

// File: rtl/sharpen_window_gen.sv
// 3x3 window generator for the sharpen MAC: three rotating line buffers feed per-row 3-tap shifters.
// Define WINGEN_FRAME_DONE_EN to add the frameDone end-of-frame strobe.
module sharpen_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   inPixel,
    input  logic                    inPixelValid,
    output logic [9*DATA_WIDTH-1:0] outWindow,
`ifdef WINGEN_FRAME_DONE_EN
    output logic                    frameDone,
`endif
    output logic                    outWindowValid
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [0:0]      state_q, state_d;
    logic [1:0]      wr_line_q, wr_line_d;
    logic [9*DW-1:0] taps_q, taps_d;
    logic [9*DW-1:0] out_window_q, out_window_d;
    logic            out_valid_q, out_valid_d;
`ifdef WINGEN_FRAME_DONE_EN
    logic            frame_done_q, frame_done_d;
`endif

    logic [DW-1:0] rd_data [3];
    logic [DW-1:0] src [3];
    logic [1:0]    old_sel, mid_sel;
    logic          col_last, row_last;

    // Reads are combinational so the taps load on the same edge that accepts the pixel.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_line
            logic [DW-1:0] line_mem [IMG_WIDTH];
            always_ff @(posedge clk) begin
                if (inPixelValid && wr_line_q == 2'(gi))
                    line_mem[col_q] <= inPixel;
            end
            assign rd_data[gi] = line_mem[col_q];
        end
    endgenerate

    always_comb begin
        col_last = (col_q == CW'(IMG_WIDTH - 1));
        row_last = (row_q == RW'(IMG_HEIGHT - 1));
        case (wr_line_q)
            2'd0:    begin old_sel = 2'd1; mid_sel = 2'd2; end
            2'd1:    begin old_sel = 2'd2; mid_sel = 2'd0; end
            default: begin old_sel = 2'd0; mid_sel = 2'd1; end
        endcase
        src[0] = rd_data[old_sel];
        src[1] = rd_data[mid_sel];
        src[2] = inPixel;

        col_d        = col_q;
        row_d        = row_q;
        state_d      = state_q;
        wr_line_d    = wr_line_q;
        taps_d       = taps_q;
        out_window_d = out_window_q;
        out_valid_d  = 1'b0;
`ifdef WINGEN_FRAME_DONE_EN
        frame_done_d = 1'b0;
`endif

        if (inPixelValid) begin
            for (int r = 0; r < 3; r++) begin
                taps_d[DW*(3*r)   +: DW] = taps_q[DW*(3*r+1) +: DW];
                taps_d[DW*(3*r+1) +: DW] = taps_q[DW*(3*r+2) +: DW];
                taps_d[DW*(3*r+2) +: DW] = src[r];
            end
            if (state_q == ST_RUN && col_q >= CW'(2)) begin
                out_valid_d  = 1'b1;
                out_window_d = taps_d;
            end
            if (col_last) begin
                col_d     = '0;
                wr_line_d = (wr_line_q == 2'd2) ? 2'd0 : wr_line_q + 2'd1;
                if (row_last) begin
                    row_d   = '0;
                    state_d = ST_FILL;
`ifdef WINGEN_FRAME_DONE_EN
                    frame_done_d = 1'b1;
`endif
                end else begin
                    row_d = row_q + RW'(1);
                    if (row_q == RW'(1))
                        state_d = ST_RUN;
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= ST_FILL;
            wr_line_q    <= 2'd0;
            taps_q       <= '0;
            out_window_q <= '0;
            out_valid_q  <= 1'b0;
`ifdef WINGEN_FRAME_DONE_EN
            frame_done_q <= 1'b0;
`endif
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            state_q      <= state_d;
            wr_line_q    <= wr_line_d;
            taps_q       <= taps_d;
            out_window_q <= out_window_d;
            out_valid_q  <= out_valid_d;
`ifdef WINGEN_FRAME_DONE_EN
            frame_done_q <= frame_done_d;
`endif
        end
    end

    assign outWindow      = out_window_q;
    assign outWindowValid = out_valid_q;
`ifdef WINGEN_FRAME_DONE_EN
    assign frameDone      = frame_done_q;
`endif

endmodule
